imm_extend_pipe: RTL

Parametrised, pipelined immediate-extension unit for the datapath's decode stage. It accepts an IN_WIDTH immediate plus a mode code and produces an OUT_WIDTH operand in one of four forms: sign-extended, zero-extended, upper-placed (LUI) or sign-extended-and-shifted (branch offset). A 2-entry output buffer with valid/ready handshakes on both sides gives full throughput under backpressure, so the unit can sit between decode and a stallable execute stage.

---
 rtl/imm_extend_pipe.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/imm_extend_pipe.sv
// Immediate-extension unit for the decode stage: sign/zero/upper/branch forms
// computed on the input side and held in a 2-entry output buffer with valid/ready handshakes.
module imm_extend_pipe #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int SHIFT     = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [1:0]           out_mode
);

  localparam int PAD_W = OUT_WIDTH - IN_WIDTH;

  // The state encoding doubles as the buffer occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  function automatic logic [OUT_WIDTH-1:0] extend_imm(
    input logic [IN_WIDTH-1:0] imm,
    input logic [1:0]          mode
  );
    logic [OUT_WIDTH-1:0] sext;
    logic [OUT_WIDTH-1:0] res;
    sext = {{PAD_W{imm[IN_WIDTH-1]}}, imm};
    case (mode)
      2'b00:   res = sext;
      2'b01:   res = {{PAD_W{1'b0}}, imm};
      2'b10:   res = {imm, {PAD_W{1'b0}}};
      2'b11:   res = sext << SHIFT;
      default: res = '0;
    endcase
    return res;
  endfunction

  occ_e                 state_q, state_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [OUT_WIDTH-1:0] data_mem_q [2];
  logic [OUT_WIDTH-1:0] data_mem_d [2];
  logic [1:0]           mode_mem_q [2];
  logic [1:0]           mode_mem_d [2];
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]           out_mode_q, out_mode_d;
  logic                 push_s;
  logic                 pop_s;
  logic [OUT_WIDTH-1:0] ext_s;

  assign push_s = in_valid & in_ready_q;
  assign pop_s  = out_valid_q & out_ready;
  assign ext_s  = extend_imm(in_data, in_mode);

  // Occupancy transitions, pointer advance and storage write.
  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    data_mem_d[0] = data_mem_q[0];
    data_mem_d[1] = data_mem_q[1];
    mode_mem_d[0] = mode_mem_q[0];
    mode_mem_d[1] = mode_mem_q[1];

    case (state_q)
      EMPTY: begin
        if (push_s) begin
          state_d = ONE;
        end else begin
          state_d = EMPTY;
        end
      end
      ONE: begin
        if (push_s && !pop_s) begin
          state_d = FULL;
        end else if (!push_s && pop_s) begin
          state_d = EMPTY;
        end else begin
          state_d = ONE;
        end
      end
      FULL: begin
        if (pop_s) begin
          state_d = ONE;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (push_s) begin
      data_mem_d[wr_ptr_q] = ext_s;
      mode_mem_d[wr_ptr_q] = in_mode;
      wr_ptr_d             = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Outputs are registered copies of the next head entry and occupancy flags.
  always_comb begin
    out_data_d  = data_mem_d[rd_ptr_d];
    out_mode_d  = mode_mem_d[rd_ptr_d];
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  // State, storage and output registers; reset clears everything and drops in-flight data.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q       <= EMPTY;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      data_mem_q[0] <= '0;
      data_mem_q[1] <= '0;
      mode_mem_q[0] <= 2'b00;
      mode_mem_q[1] <= 2'b00;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_mode_q    <= 2'b00;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      data_mem_q[0] <= data_mem_d[0];
      data_mem_q[1] <= data_mem_d[1];
      mode_mem_q[0] <= mode_mem_d[0];
      mode_mem_q[1] <= mode_mem_d[1];
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_mode_q    <= out_mode_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mode  = out_mode_q;

endmodule
